// File: rtl/grf_write_arbiter_if.sv
// Bundle of the W-stage, MD-result and GRF write-port signals seen by grf_write_arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding pipeline's view.
interface grf_write_arbiter_if #(
  parameter int AW = 1
);
  logic          wb_we;
  logic [4:0]    wb_dst;
  logic [31:0]   wb_data;
  logic [31:0]   wb_pc;
  logic          md_valid;
  logic [4:0]    md_dst;
  logic [31:0]   md_data;
  logic [31:0]   md_pc;
  logic          md_ready;
  logic          grf_we;
  logic [4:0]    grf_dst;
  logic [31:0]   grf_data;
  logic [31:0]   grf_pc;
  logic [31:0]   pending_mask;
  logic [AW:0]   md_count;

  modport slave (
    input  wb_we, wb_dst, wb_data, wb_pc,
    input  md_valid, md_dst, md_data, md_pc,
    output md_ready, grf_we, grf_dst, grf_data, grf_pc,
    output pending_mask, md_count
  );

  modport master (
    output wb_we, wb_dst, wb_data, wb_pc,
    output md_valid, md_dst, md_data, md_pc,
    input  md_ready, grf_we, grf_dst, grf_data, grf_pc,
    input  pending_mask, md_count
  );
endinterface

// File: rtl/grf_write_arbiter.sv
// Shares the single GRF write port between the W stage (absolute priority) and a small FIFO of MD results.
// Queued results drain into idle port cycles. Entries overwritten by a younger W write are killed.
module grf_write_arbiter #(
  parameter int AW    = 1,
  parameter int DEPTH = 2**AW
) (
  input logic              clk,
  input logic              rst,
  grf_write_arbiter_if.slave bus
);

  logic [4:0]  dst_q  [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [DEPTH-1:0] live_q;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  logic wb_active;
  logic full;
  logic head_exists;
  logic head_live;
  logic pop;
  logic push_store;

  assign wb_active   = bus.wb_we & (bus.wb_dst != 5'd0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign head_exists = (count != '0);
  assign head_live   = live_q[rd_ptr];
  // A killed head is discarded without using the port, so it pops even when W is writing.
  assign pop         = head_exists & (~head_live | ~wb_active);
  assign push_store  = bus.md_valid & ~full & (bus.md_dst != 5'd0);
  assign count_nxt   = count + (AW+1)'(push_store) - (AW+1)'(pop);

  assign bus.md_ready = ~full;
  assign bus.md_count = count;

  // Control state: pointers, occupancy, live bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_active && live_q[i] && (dst_q[i] == bus.wb_dst))
          live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // Applied last so a result pushed this cycle is not killed by this cycle's W write.
      if (push_store) begin
        live_q[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Payload storage, written only on push
  always_ff @(posedge clk) begin
    if (push_store) begin
      dst_q[wr_ptr]  <= bus.md_dst;
      data_q[wr_ptr] <= bus.md_data;
      pc_q[wr_ptr]   <= bus.md_pc;
    end
  end

  // Write-port mux
  always_comb begin
    bus.grf_we   = 1'b0;
    bus.grf_dst  = bus.wb_dst;
    bus.grf_data = bus.wb_data;
    bus.grf_pc   = bus.wb_pc;
    if (wb_active) begin
      bus.grf_we = 1'b1;
    end else if (head_exists && head_live) begin
      bus.grf_we   = 1'b1;
      bus.grf_dst  = dst_q[rd_ptr];
      bus.grf_data = data_q[rd_ptr];
      bus.grf_pc   = pc_q[rd_ptr];
    end
  end

  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i])
        bus.pending_mask[dst_q[i]] = 1'b1;
    end
    bus.pending_mask[0] = 1'b0;
  end

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Shares the single GRF write port between the pipeline W stage and the multiply/divide unit's result path.
- W stage has absolute priority, since the pipeline cannot stall at W.
- MD results queue in a small FIFO and drain into idle write-port cycles.
- Exports a pending-destination mask so decode stalls RAW/WAW hazards on queued registers.
- Sits between W stage, MD unit and grf; drives grf write controls directly.

Parameters:
- AW, 1: FIFO pointer width.
- DEPTH, 2**AW: FIFO entries. Legal AW is 1..3.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  W-stage write request.
- wb_dst  in  5  W-stage destination register.
- wb_data  in  32  W-stage write data.
- wb_pc  in  32  W-stage PC, for write trace.
- md_valid  in  1  MD result offered.
- md_dst  in  5  MD destination register.
- md_data  in  32  MD result data.
- md_pc  in  32  PC of the MD instruction.
- md_ready  out  1  FIFO can accept; equals !full.
- grf_we  out  1  write enable to grf.
- grf_dst  out  5  write address to grf.
- grf_data  out  32  write data to grf.
- grf_pc  out  32  PC forwarded to grf.
- pending_mask  out  32  bit r set iff a live queued entry targets r; bit 0 always 0.
- md_count  out  AW+1  FIFO occupancy, including killed entries.

Behaviour:
- Reset (async, rst=1): wr_ptr, rd_ptr and count go to 0; all entry live bits go to 0. Outputs: md_ready=1, grf_we=0, pending_mask=0, md_count=0. Payload registers are not reset.
- wb_active = wb_we & (wb_dst != 0).
- Push: md_valid & md_ready at posedge.
  - md_dst != 0: store {dst, data, pc}, live=1, wr_ptr++.
  - md_dst == 0: handshake completes, nothing stored, count unchanged.
- No bypass. A pushed result reaches grf_we no earlier than the cycle after the push.
- Output mux (combinational):
  - wb_active: grf = W-stage fields, grf_we=1.
  - else if head exists and head.live: grf = head fields, grf_we=1; pop at posedge.
  - else: grf_we=0, grf_dst/data/pc = W-stage fields.
- Killed head (live=0): popped at the next posedge without using the port, regardless of wb_active. At most one pop per cycle.
- Kill rule (WAW): when wb_active, every queued live entry with dst==wb_dst gets live<=0 at that posedge. The W instruction is younger and its value must survive.
  - An entry pushed in the same cycle is NOT killed by that cycle's W write.
- Full: md_ready=0 when count==DEPTH, even if a pop occurs the same cycle. Push and pop in one cycle on a non-full FIFO leave count unchanged.
- Pointers wrap modulo DEPTH; count saturates at neither end by construction.
- pending_mask: OR over all slots of live & (onehot(dst)), combinational from registered state.
- Starvation: MD drains only in cycles without wb_active. Forward progress is guaranteed by decode stalling on pending_mask and on md_ready=0.
- rst asserted mid-operation: queued results are discarded immediately, with no partial write.

Test Plan:
- Reset with rst=1 asynchronously, no clock -> md_ready=1, grf_we=0, pending_mask=0, md_count=0.
- MD push dst=5, data=0x1234 with W idle -> pending_mask=0x20 next cycle, grf_we=1/grf_dst=5/grf_data=0x1234 that cycle, then mask=0 and md_count=0.
- W writes dst=3 every cycle for 4 cycles while MD pushes dst=7 then dst=8 -> md_count=2, md_ready=0, third push refused; after W goes idle, $7 is written, then $8, one per cycle in order.
- Queue dst=9 data=0xAAAA, then W writes dst=9 data=0xBBBB -> entry killed, pending_mask bit9 clears, grf sees only the 0xBBBB write, killed slot pops with no write.
- MD push dst=0 -> accepted, md_count stays 0, no grf write.
- rst pulse while md_count=2 -> count=0 and mask=0 asynchronously; no subsequent grf_we.
